lvt_memory_serial_harness: RTL and testbench
============================================

Name: lvt_memory_serial_harness

Overview:
- Parametrised successor to the serial-pin LVT memory synthesis harness.
- Reads a full multi-port command frame (addresses, write data, write enables) in over one serial pin and issues it to lvt_memory_pipelined as a single transaction.
- Waits a configured read latency, captures every port's read data, and shifts it out serially with a valid qualifier.
- Adds reset, frame-length checking, busy and error reporting, and overlap of next-frame loading with the current transaction.

Parameters:
- WIDTH, 32, data bits per port.
- DEPTH, 512, memory words; AW = $clog2(DEPTH) is derived.
- PORTS, 2, memory ports. Each port is a write port when its en bit is 1, otherwise a read port.
- MEM_LAT, 2, cycles from memory inputs presented to q valid in lvt_memory_pipelined.
- Derived: F = PORTS*(AW+WIDTH+1) frame bits; O = PORTS*WIDTH output bits.

Ports:
- clk, input, 1, sole clock; all logic on its rising edge.
- rst, input, 1, synchronous active-high reset.
- d, input, 1, serial frame bit.
- d_valid, input, 1, shift d into the frame register this cycle.
- load, input, 1, request issue of the current frame.
- busy, output, 1, transaction in flight.
- q, output, 1, serial read-data bit.
- q_valid, output, 1, q carries a valid bit.
- frame_done, output, 1, one-cycle pulse at end of output stream.
- err_short, output, 1, sticky: load seen with an incomplete frame.
- err_overrun, output, 1, sticky: load seen while busy.

Behaviour:
- Input stage: d, d_valid and load are registered once (d_r, d_valid_r, load_r) before any use.

Frame register (F bits):
- On d_valid_r: shift left, d_r enters bit 0.
- Bit counter saturates at F.
- Layout MSB to LSB:
  - en[PORTS-1:0] (bits F-1..F-PORTS);
  - data, with port i at slice [(i+1)*WIDTH-1 -: WIDTH] of the data field;
  - addr, with port i at slice [(i+1)*AW-1 -: AW] of the addr field.
- The first bit received ends in bit F-1.
- The frame register accepts shifts in every state, so the next frame can be loaded while busy.

FSM states: IDLE, ISSUE, WAIT, CAPTURE, SHIFT_OUT.
- IDLE, load_r=1, counter==F: go to ISSUE. Copy addr/data/en from the frame into the memory-input registers, and clear the bit counter (a concurrent d_valid_r counts as 1).
- IDLE, load_r=1, counter<F: stay in IDLE, set err_short, frame and counter unchanged.
- ISSUE: en presented for exactly this one cycle; en is 0 in all other states. Go to WAIT.
- WAIT: wait counter runs MEM_LAT-1 cycles, then go to CAPTURE.
- CAPTURE: the output shift register (O bits) loads lvt_q, port PORTS-1 in the MSB slice. Go to SHIFT_OUT.
- SHIFT_OUT: q = MSB, shift left; q_valid=1 for exactly O cycles. Then go to IDLE with frame_done=1 for one cycle.
- load_r in any non-IDLE state: ignored, sets err_overrun; the stream is not disturbed.

Timing:
- Latency: load at cycle t gives ISSUE at t+2 and the first q_valid at t+3+MEM_LAT.
- The last q_valid is at t+2+MEM_LAT+O; frame_done is the cycle after it.
- busy=1 from cycle t+2 through the last q_valid cycle inclusive, i.e. all non-IDLE states.

Reset:
- rst sampled high at an edge: state=IDLE; all counters, the frame register, the output shift register and en cleared.
- Outputs q, q_valid, busy, frame_done, err_* = 0 from that edge, including when reset lands mid-transaction.
- Memory array contents are not cleared.

Memory-side rules:
- Same-address multi-port writes and read-during-write follow lvt_memory_pipelined semantics; the harness adds no arbitration.
- Error flags clear only on rst.

Test Plan (WIDTH=8, DEPTH=16, PORTS=2, MEM_LAT=2; F=26, O=16):
- Reset: hold rst 2 cycles with random d/d_valid/load → all outputs 0; busy stays 0 with no load.
- Write frame en=01, addr0=3, data0=0xA5, addr1=7, data1=0x00; shift 26 bits, load at t → busy at t+2, q_valid cycles t+5..t+20, frame_done at t+21, err_*=0.
- Read frame en=00, addr0=3, addr1=3 → serial stream 0xA5A5, MSB first, 16 q_valid cycles.
- Dual write en=11, addr0=1 data 0x3C, addr1=2 data 0xC3, then read addr0=2, addr1=1 → stream 0x3CC3.
- Load after 25 bits → err_short=1, busy stays 0. Then 1 more bit and load → normal transaction.
- Load during SHIFT_OUT → err_overrun=1, stream intact. Next frame shifted during busy and issued after frame_done → correct data.
- rst mid SHIFT_OUT → q_valid=0 and busy=0 from the reset edge. Re-read addr3 afterwards → 0xA5 (memory preserved).

Source files
------------

// File: rtl/lvt_memory_serial_harness.sv
// Multi-port LVT memory: one bank per port, live-value table selects the freshest bank per address.
// Latency: MEM_LAT cycles from inputs to q_o; reads return the pre-write contents of that cycle.
// Backpressure: none; accepts a new input set every cycle.
module lvt_memory_pipelined #(
   parameter int WIDTH   = 32,
   parameter int DEPTH   = 512,
   parameter int PORTS   = 2,
   parameter int MEM_LAT = 2
) (
   input  logic                             clk_i,
   input  logic [PORTS-1:0]                 we_i,
   input  logic [PORTS*$clog2(DEPTH)-1:0]   addr_i,
   input  logic [PORTS*WIDTH-1:0]           data_i,
   output logic [PORTS*WIDTH-1:0]           q_o
);
   localparam int AW = $clog2(DEPTH);
   localparam int LW = (PORTS > 1) ? $clog2(PORTS) : 1;

   logic [WIDTH-1:0]       bank_q    [PORTS][DEPTH];
   logic [LW-1:0]          lvt_tbl_q [DEPTH];
   logic [PORTS*WIDTH-1:0] rd_d;
   logic [PORTS*WIDTH-1:0] pipe_q    [MEM_LAT];

   // Later loop iterations win the table update, so the highest-numbered port owns a same-address write.
   always_ff @(posedge clk_i) begin
      for (int w = 0; w < PORTS; w++) begin
         if (we_i[w]) begin
            bank_q[w][addr_i[w*AW +: AW]] <= data_i[w*WIDTH +: WIDTH];
            lvt_tbl_q[addr_i[w*AW +: AW]] <= LW'(w);
         end
      end
   end

   always_comb begin
      rd_d = '0;
      for (int r = 0; r < PORTS; r++) begin
         rd_d[r*WIDTH +: WIDTH] = bank_q[lvt_tbl_q[addr_i[r*AW +: AW]]][addr_i[r*AW +: AW]];
      end
   end

   always_ff @(posedge clk_i) begin
      pipe_q[0] <= rd_d;
      for (int i = 1; i < MEM_LAT; i++) begin
         pipe_q[i] <= pipe_q[i-1];
      end
   end

   assign q_o = pipe_q[MEM_LAT-1];
endmodule

// Serial harness: shifts in a command frame, issues it to the LVT memory, shifts read data out.
// Latency: load at t -> memory issue at t+2, first q_valid at t+3+MEM_LAT, O serial bits.
// Backpressure: none; loads while busy are dropped and flagged in err_overrun.
module lvt_memory_serial_harness #(
   parameter int WIDTH   = 32,
   parameter int DEPTH   = 512,
   parameter int PORTS   = 2,
   parameter int MEM_LAT = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   input  logic d_valid,
   input  logic load,
   output logic busy,
   output logic q,
   output logic q_valid,
   output logic frame_done,
   output logic err_short,
   output logic err_overrun
);
   localparam int AW = $clog2(DEPTH);
   localparam int F  = PORTS * (AW + WIDTH + 1);
   localparam int O  = PORTS * WIDTH;
   localparam int CW = $clog2(F + 1);
   localparam int SW = $clog2(O + 1);
   localparam int WW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

   typedef enum logic [2:0] {
      IDLE,
      ISSUE,
      WAIT,
      CAPTURE,
      SHIFT_OUT
   } state_t;

   state_t                 state_q, state_d;
   logic                   d_r_q, d_valid_r_q, load_r_q;
   logic [F-1:0]           frame_q, frame_d;
   logic [CW-1:0]          bit_cnt_q, bit_cnt_d;
   logic [PORTS*AW-1:0]    addr_q, addr_d;
   logic [PORTS*WIDTH-1:0] data_q, data_d;
   logic [PORTS-1:0]       en_q, en_d;
   logic [WW-1:0]          wait_cnt_q, wait_cnt_d;
   logic [SW-1:0]          sh_cnt_q, sh_cnt_d;
   logic [O-1:0]           out_q, out_d;
   logic                   frame_done_q, frame_done_d;
   logic                   err_short_q, err_short_d;
   logic                   err_overrun_q, err_overrun_d;
   logic [O-1:0]           lvt_q;

   lvt_memory_pipelined #(
      .WIDTH   (WIDTH),
      .DEPTH   (DEPTH),
      .PORTS   (PORTS),
      .MEM_LAT (MEM_LAT)
   ) u_mem (
      .clk_i  (clk),
      .we_i   (en_q),
      .addr_i (addr_q),
      .data_i (data_q),
      .q_o    (lvt_q)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         d_r_q         <= 1'b0;
         d_valid_r_q   <= 1'b0;
         load_r_q      <= 1'b0;
         frame_q       <= '0;
         bit_cnt_q     <= '0;
         addr_q        <= '0;
         data_q        <= '0;
         en_q          <= '0;
         wait_cnt_q    <= '0;
         sh_cnt_q      <= '0;
         out_q         <= '0;
         frame_done_q  <= 1'b0;
         err_short_q   <= 1'b0;
         err_overrun_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         d_r_q         <= d;
         d_valid_r_q   <= d_valid;
         load_r_q      <= load;
         frame_q       <= frame_d;
         bit_cnt_q     <= bit_cnt_d;
         addr_q        <= addr_d;
         data_q        <= data_d;
         en_q          <= en_d;
         wait_cnt_q    <= wait_cnt_d;
         sh_cnt_q      <= sh_cnt_d;
         out_q         <= out_d;
         frame_done_q  <= frame_done_d;
         err_short_q   <= err_short_d;
         err_overrun_q <= err_overrun_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      frame_d       = frame_q;
      bit_cnt_d     = bit_cnt_q;
      addr_d        = addr_q;
      data_d        = data_q;
      en_d          = '0;
      wait_cnt_d    = wait_cnt_q;
      sh_cnt_d      = sh_cnt_q;
      out_d         = out_q;
      frame_done_d  = 1'b0;
      err_short_d   = err_short_q;
      err_overrun_d = err_overrun_q;

      // Frame shifting runs in every state so the next command can load during a transaction.
      if (d_valid_r_q) begin
         frame_d = {frame_q[F-2:0], d_r_q};
         if (bit_cnt_q != CW'(F)) begin
            bit_cnt_d = bit_cnt_q + CW'(1);
         end
      end

      case (state_q)
         IDLE: begin
            if (load_r_q) begin
               if (bit_cnt_q == CW'(F)) begin
                  state_d   = ISSUE;
                  en_d      = frame_q[F-1 -: PORTS];
                  data_d    = frame_q[PORTS*AW +: PORTS*WIDTH];
                  addr_d    = frame_q[0 +: PORTS*AW];
                  bit_cnt_d = {{(CW-1){1'b0}}, d_valid_r_q};
               end else begin
                  err_short_d = 1'b1;
               end
            end
         end
         ISSUE: begin
            wait_cnt_d = '0;
            state_d    = (MEM_LAT > 1) ? WAIT : CAPTURE;
         end
         WAIT: begin
            if (wait_cnt_q == WW'(MEM_LAT - 2)) begin
               state_d = CAPTURE;
            end else begin
               wait_cnt_d = wait_cnt_q + WW'(1);
            end
         end
         CAPTURE: begin
            out_d    = lvt_q;
            sh_cnt_d = '0;
            state_d  = SHIFT_OUT;
         end
         SHIFT_OUT: begin
            out_d = {out_q[O-2:0], 1'b0};
            if (sh_cnt_q == SW'(O - 1)) begin
               state_d      = IDLE;
               frame_done_d = 1'b1;
            end else begin
               sh_cnt_d = sh_cnt_q + SW'(1);
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if (load_r_q && (state_q != IDLE)) begin
         err_overrun_d = 1'b1;
      end
   end

   assign busy        = (state_q != IDLE);
   assign q_valid     = (state_q == SHIFT_OUT);
   assign q           = q_valid & out_q[O-1];
   assign frame_done  = frame_done_q;
   assign err_short   = err_short_q;
   assign err_overrun = err_overrun_q;
endmodule

// File: tb/tb_lvt_memory_serial_harness.sv
// Scoreboarded bench for lvt_memory_serial_harness with WIDTH=8, DEPTH=16, PORTS=2, MEM_LAT=2.
module tb_lvt_memory_serial_harness;
   localparam int W = 8;
   localparam int D = 16;
   localparam int F = 26;
   localparam int O = 16;

   logic clk = 1'b0;
   logic rst, d, d_valid, load;
   logic busy, q, q_valid, frame_done, err_short, err_overrun;

   int cyc    = 0;
   int checks = 0;
   int errors = 0;
   int load_t = 0;

   typedef struct packed {
      logic [15:0] exp;
      logic [15:0] mask;
      logic [31:0] start;
   } exp_t;

   exp_t       sb[$];
   logic [7:0] mem_m [D];
   logic       known [D];
   logic       fd_exp = 1'b0;

   lvt_memory_serial_harness #(
      .WIDTH   (W),
      .DEPTH   (D),
      .PORTS   (2),
      .MEM_LAT (2)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .d           (d),
      .d_valid     (d_valid),
      .load        (load),
      .busy        (busy),
      .q           (q),
      .q_valid     (q_valid),
      .frame_done  (frame_done),
      .err_short   (err_short),
      .err_overrun (err_overrun)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [25:0] mk_frame(input logic [1:0] en, input logic [3:0] a0,
                                            input logic [7:0] d0, input logic [3:0] a1,
                                            input logic [7:0] d1);
      return {en, d1, d0, a1, a0};
   endfunction

   // Reference: every port reads the memory as it was before this transaction, then writes
   // land in port order so port 1 wins a same-address write.
   function automatic exp_t model(input logic [1:0] en, input logic [3:0] a0, input logic [7:0] d0,
                                  input logic [3:0] a1, input logic [7:0] d1);
      exp_t e;
      e.exp   = {mem_m[a1], mem_m[a0]};
      e.mask  = {known[a1] ? 8'hFF : 8'h00, known[a0] ? 8'hFF : 8'h00};
      e.start = 0;
      if (en[0]) begin mem_m[a0] = d0; known[a0] = 1'b1; end
      if (en[1]) begin mem_m[a1] = d1; known[a1] = 1'b1; end
      return e;
   endfunction

   task automatic send_bits(input logic [25:0] f, input int hi, input int lo, input bit gaps);
      for (int i = hi; i >= lo; i--) begin
         if (gaps && ($urandom_range(0, 3) == 0)) begin
            d       = 1'($urandom_range(0, 1));
            d_valid = 1'b0;
            tick();
         end
         d       = f[i];
         d_valid = 1'b1;
         tick();
      end
      d_valid = 1'b0;
   endtask

   task automatic do_load();
      load   = 1'b1;
      load_t = cyc;
      tick();
      load   = 1'b0;
   endtask

   task automatic push_exp(input exp_t e);
      exp_t x;
      x       = e;
      x.start = 32'(load_t + 5);
      sb.push_back(x);
   endtask

   task automatic issue(input logic [1:0] en, input logic [3:0] a0, input logic [7:0] d0,
                        input logic [3:0] a1, input logic [7:0] d1, input bit gaps);
      exp_t e;
      e = model(en, a0, d0, a1, d1);
      send_bits(mk_frame(en, a0, d0, a1, d1), F - 1, 0, gaps);
      do_load();
      push_exp(e);
   endtask

   task automatic wait_idle();
      int n = 0;
      while ((busy || (sb.size() != 0) || fd_exp) && (n < 300)) begin
         @(negedge clk);
         n++;
      end
      if (n >= 300) begin
         checks++;
         errors++;
         $display("FAIL wait_idle: timed out busy=%0b pending=%0d", busy, sb.size());
         sb.delete();
      end
      tick();
   endtask

   task automatic wait_qvalid();
      int n = 0;
      @(negedge clk);
      while (!q_valid && (n < 100)) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) begin
         checks++;
         errors++;
         $display("FAIL wait_qvalid: q_valid never rose, got 0 expected 1");
      end
   endtask

   // Monitor: assembles each serial stream and compares it against the scoreboard head.
   initial begin
      int          nbits = 0;
      logic [15:0] stream = '0;
      int          start_c = 0;
      exp_t        e;
      forever begin
         @(negedge clk);
         if (rst) begin
            nbits  = 0;
            fd_exp = 1'b0;
            sb.delete();
         end else if (fd_exp) begin
            chk("frame_done_pulse", 32'(frame_done), 32'd1);
            chk("q_valid_after_end", 32'(q_valid), 32'd0);
            fd_exp = 1'b0;
         end else begin
            if (frame_done) chk("frame_done_spurious", 32'(frame_done), 32'd0);
            if (q_valid) begin
               if (nbits == 0 && sb.size() == 0) begin
                  chk("unexpected_q_valid", 32'(q_valid), 32'd0);
               end else begin
                  if (nbits == 0) start_c = cyc;
                  stream = {stream[14:0], q};
                  nbits++;
                  if (nbits == O) begin
                     e = sb.pop_front();
                     chk("stream_data", 32'(stream & e.mask), 32'(e.exp & e.mask));
                     chk("stream_first_cycle", 32'(start_c), e.start);
                     chk("stream_last_cycle", 32'(cyc), e.start + 32'd15);
                     nbits  = 0;
                     fd_exp = 1'b1;
                  end
               end
            end
         end
      end
   end

   initial begin
      exp_t        e;
      logic [25:0] f;
      logic [3:0]  ra0, ra1;

      rst = 1'b1; d = 1'b0; d_valid = 1'b0; load = 1'b0;
      for (int i = 0; i < D; i++) begin
         known[i] = 1'b0;
         mem_m[i] = '0;
      end

      // Reset with random input activity.
      tick();
      d = 1'($urandom_range(0, 1)); d_valid = 1'($urandom_range(0, 1)); load = 1'($urandom_range(0, 1));
      tick();
      @(negedge clk);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_q", 32'(q), 0);
      chk("rst_q_valid", 32'(q_valid), 0);
      chk("rst_frame_done", 32'(frame_done), 0);
      chk("rst_err_short", 32'(err_short), 0);
      chk("rst_err_overrun", 32'(err_overrun), 0);
      rst = 1'b0; d_valid = 1'b0; load = 1'b0;
      repeat (4) @(negedge clk);
      chk("idle_busy_no_load", 32'(busy), 0);
      chk("idle_q_valid_no_load", 32'(q_valid), 0);
      tick();

      // Single-port write with busy timing.
      issue(2'b01, 4'd3, 8'hA5, 4'd7, 8'h00, 1'b0);
      @(negedge clk); chk("busy_t+1", 32'(busy), 0);
      @(negedge clk); chk("busy_t+2", 32'(busy), 1);
      wait_idle();
      chk("err_short_clean", 32'(err_short), 0);
      chk("err_overrun_clean", 32'(err_overrun), 0);

      // Dual read of the same address, then dual write followed by crossed reads.
      issue(2'b00, 4'd3, 8'h11, 4'd3, 8'h22, 1'b0);
      wait_idle();
      issue(2'b11, 4'd1, 8'h3C, 4'd2, 8'hC3, 1'b0);
      wait_idle();
      issue(2'b00, 4'd2, 8'h00, 4'd1, 8'h00, 1'b0);
      wait_idle();

      // Short frame: 25 bits then load is rejected, one more bit completes it.
      f = mk_frame(2'b00, 4'd3, 8'h00, 4'd1, 8'h00);
      send_bits(f, F - 1, 1, 1'b0);
      do_load();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("short_busy_low", 32'(busy), 0);
      end
      chk("err_short_set", 32'(err_short), 1);
      tick();
      send_bits(f, 0, 0, 1'b0);
      e = model(2'b00, 4'd3, 8'h00, 4'd1, 8'h00);
      do_load();
      push_exp(e);
      wait_idle();

      // Load during the output stream, with the next frame shifted in while busy.
      issue(2'b00, 4'd2, 8'h00, 4'd3, 8'h00, 1'b0);
      wait_qvalid();
      tick();
      load = 1'b1; tick(); load = 1'b0;
      f = mk_frame(2'b10, 4'd1, 8'h00, 4'd5, 8'h77);
      send_bits(f, F - 1, 0, 1'b0);
      chk("err_overrun_set", 32'(err_overrun), 1);
      chk("err_short_sticky", 32'(err_short), 1);
      wait_idle();
      e = model(2'b10, 4'd1, 8'h00, 4'd5, 8'h77);
      do_load();
      push_exp(e);
      wait_idle();

      // Reset in the middle of the output stream.
      issue(2'b00, 4'd5, 8'h00, 4'd3, 8'h00, 1'b0);
      wait_qvalid();
      repeat (4) tick();
      rst = 1'b1;
      tick();
      @(negedge clk);
      chk("midrst_q_valid", 32'(q_valid), 0);
      chk("midrst_busy", 32'(busy), 0);
      chk("midrst_frame_done", 32'(frame_done), 0);
      chk("midrst_err_short", 32'(err_short), 0);
      chk("midrst_err_overrun", 32'(err_overrun), 0);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      chk("postrst_busy", 32'(busy), 0);
      tick();
      issue(2'b00, 4'd3, 8'h00, 4'd3, 8'h00, 1'b0);
      wait_idle();

      // Randomized phase: fill the memory, then random mixed transactions.
      for (int k = 0; k < D / 2; k++) begin
         issue(2'b11, 4'(2 * k), 8'($urandom), 4'(2 * k + 1), 8'($urandom), 1'b1);
         wait_idle();
      end
      for (int k = 0; k < 14; k++) begin
         ra0 = 4'($urandom_range(0, D - 1));
         ra1 = ($urandom_range(0, 3) == 0) ? ra0 : 4'($urandom_range(0, D - 1));
         issue(2'($urandom_range(0, 3)), ra0, 8'($urandom), ra1, 8'($urandom), 1'b1);
         repeat ($urandom_range(0, 3)) tick();
         wait_idle();
      end
      chk("final_err_short", 32'(err_short), 0);
      chk("final_err_overrun", 32'(err_overrun), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      errors++;
      checks++;
      $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
